// File: rtl/imem_fetch_arbiter_if.sv
// Fetch/decode/memory/debug bundle for imem_fetch_arbiter.
// master = arbiter side, slave = memory, decode and debug side.
interface imem_fetch_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic              memread;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch_taken;
    logic [15:0]       branch_off;
    logic              busy;
    logic              done;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_valid;

    modport master (
        input  start, mem_rdata, instr_ready, branch_taken, branch_off, dbg_req, dbg_addr,
        output memread, mem_addr, instr, instr_pc, instr_valid, busy, done,
               dbg_gnt, dbg_rdata, dbg_valid
    );

    modport slave (
        output start, mem_rdata, instr_ready, branch_taken, branch_off, dbg_req, dbg_addr,
        input  memread, mem_addr, instr, instr_pc, instr_valid, busy, done,
               dbg_gnt, dbg_rdata, dbg_valid
    );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Instruction fetch sequencer with PC-relative redirect and a shared debug read port.
// FETCH_PERF_EN adds saturating fire/stall counters on perf_fetch/perf_stall.
module imem_fetch_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LAST_ADDR = 80
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FETCH_PERF_EN
    output logic [15:0] perf_fetch,
    output logic [15:0] perf_stall,
`endif
    imem_fetch_arbiter_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [ADDR_W:0] LAST_PC = (ADDR_W+1)'(LAST_ADDR);
    localparam logic [ADDR_W:0] PC_ONE  = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              last_gnt_dbg_q, last_gnt_dbg_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              dbg_valid_q, dbg_valid_d;

    logic              in_run;
    logic              accept;
    logic              redirect;
    logic              fetch_wanted;
    logic              gnt;
    logic              fire;
    logic [ADDR_W-1:0] br_target;

    always_comb begin
        in_run       = (state_q == S_RUN);
        accept       = instr_valid_q & bus.instr_ready;
        redirect     = accept & bus.branch_taken;
        fetch_wanted = in_run & (pc_q <= LAST_PC) & (!instr_valid_q | bus.instr_ready) & !redirect;
        // Debug wins outside RUN, when fetch is idle, or on alternate cycles against fetch.
        gnt          = bus.dbg_req & (!in_run | !fetch_wanted | !last_gnt_dbg_q);
        fire         = fetch_wanted & !gnt;
        br_target    = instr_pc_q + ADDR_W'(1) + ADDR_W'($signed(bus.branch_off));
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        instr_valid_d  = instr_valid_q;
        last_gnt_dbg_d = gnt;
        dbg_valid_d    = gnt;
        dbg_rdata_d    = gnt ? bus.mem_rdata : dbg_rdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                if (redirect) begin
                    pc_d          = {1'b0, br_target};
                    instr_valid_d = 1'b0;
                end else if (fire) begin
                    instr_d       = bus.mem_rdata;
                    instr_pc_d    = pc_q[ADDR_W-1:0];
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + PC_ONE;
                end else if (accept) begin
                    instr_valid_d = 1'b0;
                end
                if ((pc_q > LAST_PC) && !instr_valid_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            instr_valid_q  <= 1'b0;
            last_gnt_dbg_q <= 1'b0;
            dbg_rdata_q    <= '0;
            dbg_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            instr_valid_q  <= instr_valid_d;
            last_gnt_dbg_q <= last_gnt_dbg_d;
            dbg_rdata_q    <= dbg_rdata_d;
            dbg_valid_q    <= dbg_valid_d;
        end
    end

    assign bus.memread     = fire | gnt;
    assign bus.mem_addr    = gnt ? bus.dbg_addr : (fire ? pc_q[ADDR_W-1:0] : '0);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.busy        = in_run;
    assign bus.done        = (state_q == S_DONE);
    assign bus.dbg_gnt     = gnt;
    assign bus.dbg_rdata   = dbg_rdata_q;
    assign bus.dbg_valid   = dbg_valid_q;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_q, perf_fetch_d;
    logic [15:0] perf_stall_q, perf_stall_d;
    logic        run_entry;

    always_comb begin
        run_entry    = !in_run & bus.start;
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (run_entry) begin
            perf_fetch_d = '0;
            perf_stall_d = '0;
        end else begin
            if (fire && perf_fetch_q != '1) begin
                perf_fetch_d = perf_fetch_q + 16'd1;
            end
            if (instr_valid_q && !bus.instr_ready && perf_stall_q != '1) begin
                perf_stall_d = perf_stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Scoreboard bench for imem_fetch_arbiter: stimulus queues expected words, a negedge monitor checks them.
module tb_imem_fetch_arbiter;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LAST   = 80;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    imem_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch;
    logic [15:0] perf_stall;
`endif

    imem_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FETCH_PERF_EN
        .perf_fetch(perf_fetch),
        .perf_stall(perf_stall),
`endif
        .bus       (bus)
    );

    logic [DATA_W-1:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] dbg_q[$];
    int                errors = 0;
    int                checks = 0;

    // Program image: LW at word 0, each following word distinct.
    function automatic logic [DATA_W-1:0] prog_word(input int unsigned a);
        return 32'h8C010001 + (a << 8);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int unsigned lo, input int unsigned hi);
        for (int unsigned a = lo; a <= hi; a++) begin
            exp_q.push_back('{pc: ADDR_W'(a), word: prog_word(a)});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL instr_unexpected: got pc=%0d required none", bus.instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("instr_pc", 64'(bus.instr_pc), 64'(e.pc));
                check("instr", 64'(bus.instr), 64'(e.word));
            end
        end
        if (rst_n && bus.dbg_valid) begin
            if (dbg_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dbg_unexpected: got rdata=%0h required none", bus.dbg_rdata);
            end else begin
                check("dbg_rdata", 64'(bus.dbg_rdata), 64'(dbg_q.pop_front()));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_memread"}, 64'(bus.memread), 64'd0);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_instr"}, 64'(bus.instr), 64'd0);
        check({tag, "_instr_pc"}, 64'(bus.instr_pc), 64'd0);
        check({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_dbg_valid"}, 64'(bus.dbg_valid), 64'd0);
        check({tag, "_dbg_rdata"}, 64'(bus.dbg_rdata), 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  stall_done;
        bit  br_done;
        bit  dbg_done;
        bit  pulsed;

        for (int i = 0; i < 256; i++) mem[i] = prog_word(i);
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.instr_ready  = 1'b1;
        bus.branch_taken = 1'b0;
        bus.branch_off   = '0;
        bus.dbg_req      = 1'b0;
        bus.dbg_addr     = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Run 1: stall at 5, branch at 22 (+1), debug reads at 30, run to the end.
        push_range(0, 22);
        push_range(24, LAST);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        check("first_memread", 64'(bus.memread), 64'd1);
        check("first_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("first_valid_lat", 64'(bus.instr_valid), 64'd0);
        tick();
        check("c2_valid", 64'(bus.instr_valid), 64'd1);
        check("c2_pc", 64'(bus.instr_pc), 64'd0);
        check("c2_instr", 64'(bus.instr), 64'h8C010001);

        cyc = 0; stall_done = 0; br_done = 0; dbg_done = 0;
        while (!bus.done && cyc < 400) begin
            if (bus.instr_valid && bus.instr_pc == 5 && !stall_done) begin
                stall_done = 1;
                bus.instr_ready = 1'b0;
                repeat (3) begin
                    #1;
                    check("stall_memread", 64'(bus.memread), 64'd0);
                    check("stall_pc", 64'(bus.instr_pc), 64'd5);
                    check("stall_instr", 64'(bus.instr), 64'(prog_word(5)));
                    tick();
                    cyc++;
                end
                bus.instr_ready = 1'b1;
            end else if (bus.instr_valid && bus.instr_pc == 22 && !br_done) begin
                br_done = 1;
                bus.branch_taken = 1'b1;
                bus.branch_off   = 16'd1;
                tick();
                cyc++;
                bus.branch_taken = 1'b0;
                bus.branch_off   = '0;
                #1;
                check("bubble_valid", 64'(bus.instr_valid), 64'd0);
                check("redirect_memread", 64'(bus.memread), 64'd1);
                check("redirect_addr", 64'(bus.mem_addr), 64'd24);
                tick();
                cyc++;
                check("after_branch_pc", 64'(bus.instr_pc), 64'd24);
            end else if (bus.instr_valid && bus.instr_pc == 30 && !dbg_done) begin
                dbg_done = 1;
                bus.dbg_req  = 1'b1;
                bus.dbg_addr = 8'h10;
                dbg_q.push_back(prog_word(16));
                dbg_q.push_back(prog_word(16));
                for (int k = 0; k < 4; k++) begin
                    #1;
                    check("dbg_gnt_alt", 64'(bus.dbg_gnt), (k % 2 == 0) ? 64'd1 : 64'd0);
                    tick();
                    cyc++;
                end
                bus.dbg_req = 1'b0;
                check("dbg_fetch_valid", 64'(bus.instr_valid), 64'd1);
                check("dbg_fetch_adv", 64'(bus.instr_pc), 64'd32);
            end else begin
                tick();
                cyc++;
            end
        end
        check("run1_done", 64'(bus.done), 64'd1);
        check("run1_busy", 64'(bus.busy), 64'd0);
        check("run1_memread", 64'(bus.memread), 64'd0);
        check("run1_drained", 64'(exp_q.size()), 64'd0);
        check("dbg_drained", 64'(dbg_q.size()), 64'd0);

        // Run 2: restart from DONE, reset while word 40 is presented.
        push_range(0, 39);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.instr_valid && bus.instr_pc == 40) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("run2_reach40", 64'(bus.instr_valid && bus.instr_pc == 40), 64'd1);
        check("run2_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check("midrst_drained", 64'(exp_q.size()), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        check("post_rst_done", 64'(bus.done), 64'd0);

        // Run 3: from IDLE after reset; a start during RUN must be ignored.
        push_range(0, LAST);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0; pulsed = 0;
        while (!bus.done && cyc < 400) begin
            if (bus.instr_valid && bus.instr_pc == 10 && !pulsed) begin
                pulsed = 1;
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end else begin
                tick();
            end
            cyc++;
        end
        check("run3_done", 64'(bus.done), 64'd1);
        check("run3_busy", 64'(bus.busy), 64'd0);
        check("run3_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
